mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the CPU's two memory ports: port 1 is data read/write, port 2 is instruction fetch, read-only.
- Services both ports from one internal single-ported array of 2^ADDR_W words, with arbitration and a request/ack handshake.
- Intended to replace the zero-latency bench memory, so CPU stall and handshake logic is exercised against realistic one-access-per-cycle storage.

Parameters:
- ADDR_W, 10, word address width; array depth is 2^ADDR_W.
- DATA_W, 32, word width.
- RR_ARB, 1, 1 = round-robin between ports; 0 = fixed priority to port 1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- actRead1  input  1  port-1 read request (level, held until ack1).
- actWrite1  input  1  port-1 write request (level, held until ack1).
- select1  input  ADDR_W  port-1 word address.
- wrData1  input  DATA_W  port-1 write data.
- rdData1  output  DATA_W  port-1 read data, valid when ack1=1.
- ack1  output  1  one-cycle completion pulse for port 1.
- err1  output  1  pulses with ack1 when actRead1 and actWrite1 were both high at grant.
- fetch2  input  1  port-2 fetch request (level, held until ack2).
- select2  input  ADDR_W  port-2 word address.
- rdData2  output  DATA_W  port-2 fetch data, valid when ack2=1.
- ack2  output  1  one-cycle completion pulse for port 2.

Behaviour:
- Reset state (reset=0 at a rising edge): state=IDLE; ack1=ack2=err1=0; rdData1=rdData2=0; lastGrant=port2. Array contents are not cleared.
- FSM states:
  - IDLE: requests are sampled here.
  - ACK1: ack1=1 for this cycle only.
  - ACK2: ack2=1 for this cycle only.
- IDLE arbitration (req1 = actRead1 | actWrite1; req2 = fetch2):
  - Only req1: grant port 1.
  - Only req2: grant port 2.
  - Both with RR_ARB=1: grant the port not equal to lastGrant.
  - Both with RR_ARB=0: grant port 1.
  - Neither: stay in IDLE; acks stay 0.
- Access on the granting edge:
  - Port-1 write: mem[select1] <= wrData1; rdData1 unchanged.
  - Port-1 read: rdData1 <= mem[select1].
  - Port 2: rdData2 <= mem[select2].
  - Then lastGrant <= granted port and next state is ACK1 or ACK2.
- ACK1/ACK2 last one cycle, then return unconditionally to IDLE. Requests are ignored in ACK states.
- Latency and throughput: request sampled in IDLE at edge N; ack high and data valid from edge N until edge N+1. At most one access per 2 cycles.
- Requester protocol:
  - A requester sees ack during the ACK cycle.
  - It may drop the request or present a new one on the edge ending ACK; the next IDLE cycle samples the new value.
  - A held request is re-serviced, which is legal and idempotent for reads.
- Port-1 conflict (actRead1=actWrite1=1 at grant): perform the write only; err1=1 in the same cycle as ack1.
- rdData1/rdData2 hold their last value until the next access on the same port.
- Read/write ordering: port-1 write followed by a port-2 fetch of the same address returns the new data, because the accesses are serialized.
- Address/data width: select1/select2 use all ADDR_W bits, so no out-of-range addresses exist; wrap-around is inherent.
- Reset mid-operation:
  - reset=0 in ACK1/ACK2: ack drops at that edge; state returns to IDLE.
  - A write committed on the granting edge is retained.
  - reset=0 in IDLE with a request pending: no array access occurs.

Test Plan:
- Reset: hold reset=0 for 2 edges with actRead1=1 and fetch2=1 → ack1=ack2=err1=0, rdData1=rdData2=0, no access.
- Write/read: actWrite1=1, select1=0x005, wrData1=0xDEADBEEF → ack1=1 for exactly one cycle, one edge after sampling. Then actRead1=1, select1=0x005 → ack1 pulse with rdData1=0xDEADBEEF.
- Fetch: after the write above, fetch2=1, select2=0x005 → ack2 pulse one edge after sampling with rdData2=0xDEADBEEF; rdData1 unchanged.
- Arbitration with RR_ARB=1: after reset, actRead1=1 (select1=0x001) and fetch2=1 (select2=0x002) held continuously → ack1 at cycle 1, ack2 at cycle 3, ack1 at cycle 5 (alternating). With RR_ARB=0 → ack1 on every service, ack2 never.
- Conflict: actRead1=actWrite1=1, select1=0x010, wrData1=0x12345678 → ack1=err1=1 in the same cycle. A later read of 0x010 returns 0x12345678.
- Reset in ACK: write 0x0000CAFE to 0x3FF, drive reset=0 during the ACK1 cycle → ack1=0 after that edge, state IDLE. Release reset, read 0x3FF → rdData1=0x0000CAFE.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: two-port memory responder over one single-ported word array.
// Port 1 reads/writes data, port 2 fetches instructions (read-only). Each
// granted access completes with a one-cycle ack, so at most one access is
// performed every two cycles.
module mem_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RR_ARB = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              actRead1,
  input  logic              actWrite1,
  input  logic [ADDR_W-1:0] select1,
  input  logic [DATA_W-1:0] wrData1,
  output logic [DATA_W-1:0] rdData1,
  output logic              ack1,
  output logic              err1,
  input  logic              fetch2,
  input  logic [ADDR_W-1:0] select2,
  output logic [DATA_W-1:0] rdData2,
  output logic              ack2
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK1 = 2'd1,
    S_ACK2 = 2'd2
  } state_t;

  state_t state_q, state_d;
  // last_grant_q: 0 = port 1 was served last, 1 = port 2 was served last
  logic last_grant_q, last_grant_d;
  logic err_q, err_d;
  logic [DATA_W-1:0] rd1_q, rd2_q;

  logic req1, req2;
  logic grant1, grant2;
  logic [ADDR_W-1:0] acc_addr;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  assign req1 = actRead1 | actWrite1;
  assign req2 = fetch2;

  // Only one port may touch the array per cycle, so a single address is muxed.
  assign acc_addr = grant2 ? select2 : select1;

  // Arbitration and next-state; grants are only issued while idle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    err_d        = 1'b0;
    grant1       = 1'b0;
    grant2       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req1 && req2) begin
          if (RR_ARB != 0) begin
            grant1 = last_grant_q;
            grant2 = ~last_grant_q;
          end else begin
            grant1 = 1'b1;
          end
        end else if (req1) begin
          grant1 = 1'b1;
        end else if (req2) begin
          grant2 = 1'b1;
        end
        if (grant1) begin
          state_d      = S_ACK1;
          last_grant_d = 1'b0;
          // Read+write together is a requester error; the write still happens.
          err_d        = actRead1 & actWrite1;
        end else if (grant2) begin
          state_d      = S_ACK2;
          last_grant_d = 1'b1;
        end
      end
      S_ACK1:  state_d = S_IDLE;
      S_ACK2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, arbitration history and error flag registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  // Array write; contents survive reset, and reset blocks a pending access.
  always_ff @(posedge clock) begin
    if (reset && grant1 && actWrite1) begin
      mem[acc_addr] <= wrData1;
    end
  end

  // Registered read data per port; each holds until that port's next read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      if (grant1 && !actWrite1) rd1_q <= mem[acc_addr];
      if (grant2)               rd2_q <= mem[acc_addr];
    end
  end

  assign ack1    = (state_q == S_ACK1);
  assign ack2    = (state_q == S_ACK2);
  assign err1    = (state_q == S_ACK1) & err_q;
  assign rdData1 = rd1_q;
  assign rdData2 = rd2_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder. Two instances share all inputs:
// dut uses round-robin arbitration, dut_fp uses fixed priority to port 1.
module tb_mem_responder;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              actRead1 = 1'b0;
  logic              actWrite1 = 1'b0;
  logic [ADDR_W-1:0] select1 = '0;
  logic [DATA_W-1:0] wrData1 = '0;
  logic              fetch2 = 1'b0;
  logic [ADDR_W-1:0] select2 = '0;

  logic [DATA_W-1:0] rdData1, rdData2, rdData1_fp, rdData2_fp;
  logic              ack1, ack2, err1, ack1_fp, ack2_fp, err1_fp;

  int tests = 0;
  int fails = 0;

  mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR_ARB(1)) dut (
    .clock(clock), .reset(reset),
    .actRead1(actRead1), .actWrite1(actWrite1), .select1(select1), .wrData1(wrData1),
    .rdData1(rdData1), .ack1(ack1), .err1(err1),
    .fetch2(fetch2), .select2(select2), .rdData2(rdData2), .ack2(ack2)
  );

  mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR_ARB(0)) dut_fp (
    .clock(clock), .reset(reset),
    .actRead1(actRead1), .actWrite1(actWrite1), .select1(select1), .wrData1(wrData1),
    .rdData1(rdData1_fp), .ack1(ack1_fp), .err1(err1_fp),
    .fetch2(fetch2), .select2(select2), .rdData2(rdData2_fp), .ack2(ack2_fp)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle before sampling outputs.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    actRead1  = 1'b0;
    actWrite1 = 1'b0;
    fetch2    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; actRead1 = 1'b1; fetch2 = 1'b1; select1 = 10'h005; select2 = 10'h005;
    tick(); tick();
    $display("[TB] reset held 2 edges with requests pending");
    tests++; if (ack1 !== 1'b0) begin fails++; $display("FAIL reset_ack1 got %b want 0", ack1); end
    tests++; if (ack2 !== 1'b0) begin fails++; $display("FAIL reset_ack2 got %b want 0", ack2); end
    tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL reset_err1 got %b want 0", err1); end
    tests++; if (rdData1 !== 32'h0) begin fails++; $display("FAIL reset_rd1 got %h want 0", rdData1); end
    tests++; if (rdData2 !== 32'h0) begin fails++; $display("FAIL reset_rd2 got %h want 0", rdData2); end
    idle_all();
    reset = 1'b1;
    tick();
    tests++; if (ack1 !== 1'b0 || ack2 !== 1'b0) begin fails++; $display("FAIL reset_release_acks got %b%b want 00", ack1, ack2); end
  endtask

  task automatic test_write_read();
    actWrite1 = 1'b1; select1 = 10'h005; wrData1 = 32'hDEADBEEF;
    tick();
    $display("[TB] write [005] <= deadbeef");
    tests++; if (ack1 !== 1'b1) begin fails++; $display("FAIL wr_ack1 got %b want 1", ack1); end
    tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL wr_err1 got %b want 0", err1); end
    tests++; if (rdData1 !== 32'h0) begin fails++; $display("FAIL wr_rd1_unchanged got %h want 0", rdData1); end
    idle_all();
    tick();
    tests++; if (ack1 !== 1'b0) begin fails++; $display("FAIL wr_ack1_one_cycle got %b want 0", ack1); end
    actRead1 = 1'b1; select1 = 10'h005;
    tick();
    $display("[TB] read [005]");
    tests++; if (ack1 !== 1'b1) begin fails++; $display("FAIL rd_ack1 got %b want 1", ack1); end
    tests++; if (rdData1 !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data1 got %h want deadbeef", rdData1); end
    idle_all();
    tick();
    tests++; if (ack1 !== 1'b0) begin fails++; $display("FAIL rd_ack1_drop got %b want 0", ack1); end
    tests++; if (rdData1 !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data1_hold got %h want deadbeef", rdData1); end
  endtask

  task automatic test_fetch();
    fetch2 = 1'b1; select2 = 10'h005;
    tick();
    $display("[TB] fetch [005]");
    tests++; if (ack2 !== 1'b1) begin fails++; $display("FAIL fetch_ack2 got %b want 1", ack2); end
    tests++; if (ack1 !== 1'b0) begin fails++; $display("FAIL fetch_ack1 got %b want 0", ack1); end
    tests++; if (rdData2 !== 32'hDEADBEEF) begin fails++; $display("FAIL fetch_data2 got %h want deadbeef", rdData2); end
    tests++; if (rdData1 !== 32'hDEADBEEF) begin fails++; $display("FAIL fetch_rd1_unchanged got %h want deadbeef", rdData1); end
    idle_all();
    tick();
    tests++; if (ack2 !== 1'b0) begin fails++; $display("FAIL fetch_ack2_drop got %b want 0", ack2); end
  endtask

  task automatic test_arbitration();
    logic [DATA_W-1:0] pat;
    // Seed addresses 1 and 2 so the contended reads return known data.
    for (int a = 1; a <= 2; a++) begin
      actWrite1 = 1'b1; select1 = ADDR_W'(a); wrData1 = (a == 1) ? 32'h11111111 : 32'h22222222;
      tick();
      idle_all();
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1; actRead1 = 1'b1; select1 = 10'h001; fetch2 = 1'b1; select2 = 10'h002;
    for (int c = 1; c <= 6; c++) begin
      tick();
      $display("[TB] contention cycle %0d rr ack=%b%b fp ack=%b%b", c, ack1, ack2, ack1_fp, ack2_fp);
      // Round-robin: ack1 at 1,5; ack2 at 3. Fixed priority: ack1 at every odd cycle.
      pat = {29'd0, (c == 1 || c == 5), (c == 3), (c % 2 == 1)};
      tests++; if (ack1 !== pat[2] || ack2 !== pat[1]) begin fails++; $display("FAIL rr_cycle%0d got ack1=%b ack2=%b want %b %b", c, ack1, ack2, pat[2], pat[1]); end
      tests++; if (ack1_fp !== pat[0] || ack2_fp !== 1'b0) begin fails++; $display("FAIL fp_cycle%0d got ack1=%b ack2=%b want %b 0", c, ack1_fp, ack2_fp, pat[0]); end
      if (c == 1) begin
        tests++; if (rdData1 !== 32'h11111111) begin fails++; $display("FAIL rr_rd1 got %h want 11111111", rdData1); end
      end
      if (c == 3) begin
        tests++; if (rdData2 !== 32'h22222222) begin fails++; $display("FAIL rr_rd2 got %h want 22222222", rdData2); end
        tests++; if (rdData2_fp !== 32'h0) begin fails++; $display("FAIL fp_rd2 got %h want 0", rdData2_fp); end
      end
    end
    idle_all();
    tick();
  endtask

  task automatic test_conflict();
    actRead1 = 1'b1; actWrite1 = 1'b1; select1 = 10'h010; wrData1 = 32'h12345678;
    tick();
    $display("[TB] conflict read+write [010] <= 12345678");
    tests++; if (ack1 !== 1'b1 || err1 !== 1'b1) begin fails++; $display("FAIL conflict_ack_err got %b%b want 11", ack1, err1); end
    tests++; if (rdData1 !== 32'h11111111) begin fails++; $display("FAIL conflict_rd1_unchanged got %h want 11111111", rdData1); end
    idle_all();
    tick();
    tests++; if (err1 !== 1'b0 || ack1 !== 1'b0) begin fails++; $display("FAIL conflict_drop got %b%b want 00", ack1, err1); end
    actRead1 = 1'b1; select1 = 10'h010;
    tick();
    $display("[TB] read [010]");
    tests++; if (rdData1 !== 32'h12345678) begin fails++; $display("FAIL conflict_readback got %h want 12345678", rdData1); end
    tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL conflict_readback_err got %b want 0", err1); end
    idle_all();
    tick();
  endtask

  task automatic test_back_to_back();
    // Write immediately followed by a fetch of the same address sees new data.
    actWrite1 = 1'b1; select1 = 10'h020; wrData1 = 32'hA5A5_5A5A;
    tick();
    $display("[TB] write [020] <= a5a55a5a then fetch [020]");
    idle_all();
    fetch2 = 1'b1; select2 = 10'h020;
    tick();
    tests++; if (ack2 !== 1'b0) begin fails++; $display("FAIL b2b_no_ack_in_ack_cycle got %b want 0", ack2); end
    tick();
    tests++; if (ack2 !== 1'b1 || rdData2 !== 32'hA5A55A5A) begin fails++; $display("FAIL b2b_fetch got ack2=%b data=%h want 1 a5a55a5a", ack2, rdData2); end
    idle_all();
    tick();
  endtask

  task automatic test_reset_in_ack();
    actWrite1 = 1'b1; select1 = 10'h3FF; wrData1 = 32'h0000CAFE;
    tick();
    $display("[TB] write [3ff] <= 0000cafe, reset during ack");
    tests++; if (ack1 !== 1'b1) begin fails++; $display("FAIL rstack_ack1 got %b want 1", ack1); end
    idle_all();
    reset = 1'b0;
    tick();
    tests++; if (ack1 !== 1'b0) begin fails++; $display("FAIL rstack_ack1_drop got %b want 0", ack1); end
    tests++; if (rdData1 !== 32'h0) begin fails++; $display("FAIL rstack_rd1_cleared got %h want 0", rdData1); end
    reset = 1'b1; actRead1 = 1'b1; select1 = 10'h3FF;
    tick();
    $display("[TB] read [3ff]");
    tests++; if (ack1 !== 1'b1 || rdData1 !== 32'h0000CAFE) begin fails++; $display("FAIL rstack_readback got ack1=%b data=%h want 1 0000cafe", ack1, rdData1); end
    idle_all();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_fetch();
    test_arbitration();
    test_conflict();
    test_back_to_back();
    test_reset_in_ack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
